// File: rtl/collision_response.sv
`default_nettype none
// ============================================================================
// Module      : collision_response
// Description : Turns debounced collision / pickup levels into game
//               consequences: life loss, shield absorption, post-hit
//               invulnerability, timed speed and shield power-ups, and a
//               sticky game-over. All outputs are registered. The block is
//               held in its reset state whenever game_active is low.
//
// Ports
//   clock_100mhz                 in   system clock
//   reset_n                      in   asynchronous active-low reset
//   game_active                  in   low = synchronous clear of everything
//   is_collision                 in   obstacle contact level
//   is_speed_powerup_collision   in   speed pickup level (edge detected)
//   is_shield_powerup_collision  in   shield pickup level (edge detected)
//   lives[2:0]                   out  remaining lives
//   speed_active                 out  speed boost in effect
//   shield_active                out  shield held
//   invuln_active                out  post-hit invulnerability in effect
//   game_over                    out  sticky until game_active drops
//   hit_pulse                    out  one cycle per life lost
//   shield_break_pulse           out  one cycle when the shield absorbs a hit
//   speed_pickup_pulse           out  one cycle per accepted speed pickup
//   shield_pickup_pulse          out  one cycle per accepted shield pickup
//
// Revision    : 1.0  initial release
// ============================================================================
module collision_response #(
  parameter int CLK_PER_MS  = 100000,
  parameter int START_LIVES = 3,
  parameter int INVULN_MS   = 1500,
  parameter int SPEED_MS    = 5000,
  parameter int SHIELD_MS   = 8000
) (
  input  logic       clock_100mhz,
  input  logic       reset_n,
  input  logic       game_active,
  input  logic       is_collision,
  input  logic       is_speed_powerup_collision,
  input  logic       is_shield_powerup_collision,
  output logic [2:0] lives,
  output logic       speed_active,
  output logic       shield_active,
  output logic       invuln_active,
  output logic       game_over,
  output logic       hit_pulse,
  output logic       shield_break_pulse,
  output logic       speed_pickup_pulse,
  output logic       shield_pickup_pulse
);

  localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;

  localparam logic [PW-1:0] C_PRE_LAST    = PW'(CLK_PER_MS - 1);
  localparam logic [2:0]    C_START_LIVES = 3'(START_LIVES);
  localparam logic [15:0]   C_INVULN_MS   = 16'(INVULN_MS);
  localparam logic [15:0]   C_SPEED_MS    = 16'(SPEED_MS);
  localparam logic [15:0]   C_SHIELD_MS   = 16'(SHIELD_MS);

  localparam logic [1:0] ST_ARMED      = 2'd0;
  localparam logic [1:0] ST_INVULN     = 2'd1;
  localparam logic [1:0] ST_WAIT_CLEAR = 2'd2;
  localparam logic [1:0] ST_OVER       = 2'd3;

  // Registered state
  logic [PW-1:0] r_pre;
  logic [1:0]    r_state;
  logic [2:0]    r_lives;
  logic [15:0]   r_inv_tmr, r_spd_tmr, r_shd_tmr;
  logic          r_speed, r_shield, r_invuln, r_over;
  logic          r_hit, r_brk, r_spd_pick, r_shd_pick;
  logic          r_spd_prev, r_shd_prev;

  // Next-state values
  logic          w_ms_tick;
  logic [PW-1:0] w_pre_nxt;
  logic          w_spd_rise, w_shd_rise;
  logic [1:0]    w_state_nxt;
  logic [2:0]    w_lives_nxt;
  logic [15:0]   w_inv_tmr_nxt, w_spd_tmr_nxt, w_shd_tmr_nxt;
  logic          w_speed_nxt, w_shield_nxt, w_invuln_nxt, w_over_nxt;
  logic          w_hit_nxt, w_brk_nxt, w_spd_pick_nxt, w_shd_pick_nxt;

  always_comb begin
    w_ms_tick  = (r_pre == C_PRE_LAST);
    w_pre_nxt  = w_ms_tick ? '0 : r_pre + PW'(1);
    w_spd_rise = is_speed_powerup_collision & ~r_spd_prev;
    w_shd_rise = is_shield_powerup_collision & ~r_shd_prev;

    w_state_nxt    = r_state;
    w_lives_nxt    = r_lives;
    w_over_nxt     = r_over;
    w_invuln_nxt   = r_invuln;
    w_inv_tmr_nxt  = r_inv_tmr;
    w_speed_nxt    = r_speed;
    w_spd_tmr_nxt  = r_spd_tmr;
    w_shield_nxt   = r_shield;
    w_shd_tmr_nxt  = r_shd_tmr;
    w_hit_nxt      = 1'b0;
    w_brk_nxt      = 1'b0;
    w_spd_pick_nxt = 1'b0;
    w_shd_pick_nxt = 1'b0;

    // Power-up ageing; the flag drops on the same edge its timer hits 0.
    if (w_ms_tick && (r_state != ST_OVER)) begin
      if (r_spd_tmr != 16'd0) begin
        w_spd_tmr_nxt = r_spd_tmr - 16'd1;
        if (r_spd_tmr == 16'd1) w_speed_nxt = 1'b0;
      end
      if (r_shd_tmr != 16'd0) begin
        w_shd_tmr_nxt = r_shd_tmr - 16'd1;
        if (r_shd_tmr == 16'd1) w_shield_nxt = 1'b0;
      end
    end

    case (r_state)
      ST_ARMED: begin
        if (is_collision) begin
          // r_shield is the pre-tick, pre-pickup value, so a shield that
          // expires this very cycle still absorbs the hit.
          if (r_shield) begin
            w_shield_nxt  = 1'b0;
            w_shd_tmr_nxt = 16'd0;
            w_brk_nxt     = 1'b1;
            w_state_nxt   = ST_INVULN;
            w_invuln_nxt  = 1'b1;
            w_inv_tmr_nxt = C_INVULN_MS;
          end else begin
            w_lives_nxt = r_lives - 3'd1;
            w_hit_nxt   = 1'b1;
            if (r_lives == 3'd1) begin
              w_over_nxt  = 1'b1;
              w_state_nxt = ST_OVER;
            end else begin
              w_state_nxt   = ST_INVULN;
              w_invuln_nxt  = 1'b1;
              w_inv_tmr_nxt = C_INVULN_MS;
            end
          end
        end
      end
      ST_INVULN: begin
        if ((r_inv_tmr == 16'd0) || (w_ms_tick && (r_inv_tmr == 16'd1))) begin
          w_inv_tmr_nxt = 16'd0;
          w_invuln_nxt  = 1'b0;
          w_state_nxt   = ST_WAIT_CLEAR;
        end else if (w_ms_tick) begin
          w_inv_tmr_nxt = r_inv_tmr - 16'd1;
        end
      end
      ST_WAIT_CLEAR: begin
        if (!is_collision) w_state_nxt = ST_ARMED;
      end
      default: begin
        // OVER is absorbing; nothing advances.
      end
    endcase

    // Pickups are applied after the collision so a same-cycle shield pickup
    // re-arms a shield that just absorbed a hit.
    if (w_state_nxt == ST_OVER) begin
      w_speed_nxt   = 1'b0;
      w_shield_nxt  = 1'b0;
      w_spd_tmr_nxt = r_spd_tmr;
      w_shd_tmr_nxt = r_shd_tmr;
    end else begin
      if (w_spd_rise) begin
        w_speed_nxt    = 1'b1;
        w_spd_tmr_nxt  = C_SPEED_MS;
        w_spd_pick_nxt = 1'b1;
      end
      if (w_shd_rise) begin
        w_shield_nxt   = 1'b1;
        w_shd_tmr_nxt  = C_SHIELD_MS;
        w_shd_pick_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clock_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_pre      <= '0;
      r_state    <= ST_ARMED;
      r_lives    <= C_START_LIVES;
      r_inv_tmr  <= 16'd0;
      r_spd_tmr  <= 16'd0;
      r_shd_tmr  <= 16'd0;
      r_speed    <= 1'b0;
      r_shield   <= 1'b0;
      r_invuln   <= 1'b0;
      r_over     <= 1'b0;
      r_hit      <= 1'b0;
      r_brk      <= 1'b0;
      r_spd_pick <= 1'b0;
      r_shd_pick <= 1'b0;
      r_spd_prev <= 1'b0;
      r_shd_prev <= 1'b0;
    end else if (!game_active) begin
      r_pre      <= '0;
      r_state    <= ST_ARMED;
      r_lives    <= C_START_LIVES;
      r_inv_tmr  <= 16'd0;
      r_spd_tmr  <= 16'd0;
      r_shd_tmr  <= 16'd0;
      r_speed    <= 1'b0;
      r_shield   <= 1'b0;
      r_invuln   <= 1'b0;
      r_over     <= 1'b0;
      r_hit      <= 1'b0;
      r_brk      <= 1'b0;
      r_spd_pick <= 1'b0;
      r_shd_pick <= 1'b0;
      r_spd_prev <= 1'b0;
      r_shd_prev <= 1'b0;
    end else begin
      r_pre      <= w_pre_nxt;
      r_state    <= w_state_nxt;
      r_lives    <= w_lives_nxt;
      r_inv_tmr  <= w_inv_tmr_nxt;
      r_spd_tmr  <= w_spd_tmr_nxt;
      r_shd_tmr  <= w_shd_tmr_nxt;
      r_speed    <= w_speed_nxt;
      r_shield   <= w_shield_nxt;
      r_invuln   <= w_invuln_nxt;
      r_over     <= w_over_nxt;
      r_hit      <= w_hit_nxt;
      r_brk      <= w_brk_nxt;
      r_spd_pick <= w_spd_pick_nxt;
      r_shd_pick <= w_shd_pick_nxt;
      r_spd_prev <= is_speed_powerup_collision;
      r_shd_prev <= is_shield_powerup_collision;
    end
  end

  assign lives               = r_lives;
  assign speed_active        = r_speed;
  assign shield_active       = r_shield;
  assign invuln_active       = r_invuln;
  assign game_over           = r_over;
  assign hit_pulse           = r_hit;
  assign shield_break_pulse  = r_brk;
  assign speed_pickup_pulse  = r_spd_pick;
  assign shield_pickup_pulse = r_shd_pick;

endmodule
`default_nettype wire
